de2_115_camera_led_out: RTL and testbench

Avalon-MM slave output port that drives board LEDs from software: the write-side counterpart of the camera system's switch-input port. The CPU writes a data register directly, or sets/clears individual bits without read-modify-write. A per-bit blink mask with a programmable toggle period lets software flash LEDs without polling. Sits on the Qsys/SOPC system bus; `out_port` goes to the top-level LEDR pins.

---
 rtl/de2_115_camera_led_out_pkg.sv | 10 +
 rtl/de2_115_camera_blink_timer.sv | 40 ++++
 rtl/de2_115_camera_led_out.sv | 68 ++++++
 tb/tb_de2_115_camera_led_out.sv | 115 +++++++++++
 4 files changed

// File: rtl/de2_115_camera_led_out_pkg.sv
// de2_115_camera_led_out_pkg: register map and default widths for the LED output port.
package de2_115_camera_led_out_pkg;
   localparam int DEFAULT_DATA_WIDTH   = 18;
   localparam int DEFAULT_PERIOD_WIDTH = 24;
   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
endpackage

// File: rtl/de2_115_camera_blink_timer.sv
// de2_115_camera_blink_timer: programmable period timer; phase toggles every period+1 clocks.
module de2_115_camera_blink_timer
   import de2_115_camera_led_out_pkg::*;
#(
   parameter int PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [PERIOD_WIDTH-1:0] load_value,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    phase
);
   logic [PERIOD_WIDTH-1:0] period_q, period_d, counter_q, counter_d;
   logic                    phase_q, phase_d;

   always_comb begin
      period_d  = load ? load_value : period_q;
      counter_d = load ? load_value
                : period_q == '0 ? '0
                : counter_q == '0 ? period_q
                : counter_q - PERIOD_WIDTH'(1);
      phase_d   = !load && period_q != '0 && (counter_q == '0 ? !phase_q : phase_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_q  <= '0;
         counter_q <= '0;
         phase_q   <= 1'b0;
      end else begin
         period_q  <= period_d;
         counter_q <= counter_d;
         phase_q   <= phase_d;
      end
   end

   assign period = period_q;
   assign phase  = phase_q;
endmodule

// File: rtl/de2_115_camera_led_out.sv
// de2_115_camera_led_out: Avalon-MM LED output port with set/clear and per-bit blinking.
module de2_115_camera_led_out
   import de2_115_camera_led_out_pkg::*;
#(
   parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
   parameter int                    PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);
   logic [DATA_WIDTH-1:0]   data_q, data_d, blink_en_q, blink_en_d, out_port_q, out_port_d, wd;
   logic [31:0]             readdata_q, readdata_d;
   logic [PERIOD_WIDTH-1:0] period;
   logic                    wr, load, phase, unused_wd;

   assign unused_wd = &{1'b0, writedata};

   always_comb begin
      wr         = chipselect && !write_n;
      wd         = DATA_WIDTH'(writedata);
      load       = wr && address == ADDR_PERIOD;
      data_d     = !wr ? data_q
                 : address == ADDR_DATA     ? wd
                 : address == ADDR_OUTSET   ? data_q | wd
                 : address == ADDR_OUTCLEAR ? data_q & ~wd
                 : data_q;
      blink_en_d = (wr && address == ADDR_BLINK_EN) ? wd : blink_en_q;
      // Reads use current register values, so a same-cycle write is not visible yet.
      readdata_d = address == ADDR_DATA     ? 32'(data_q)
                 : address == ADDR_BLINK_EN ? 32'(blink_en_q)
                 : address == ADDR_PERIOD   ? 32'(period)
                 : '0;
      out_port_d = data_q ^ (blink_en_q & {DATA_WIDTH{phase}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= RESET_VALUE;
         blink_en_q <= '0;
         readdata_q <= '0;
         out_port_q <= RESET_VALUE;
      end else begin
         data_q     <= data_d;
         blink_en_q <= blink_en_d;
         readdata_q <= readdata_d;
         out_port_q <= out_port_d;
      end
   end

   de2_115_camera_blink_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .load_value (writedata[PERIOD_WIDTH-1:0]),
      .period     (period),
      .phase      (phase)
   );

   assign readdata = readdata_q;
   assign out_port = out_port_q;
endmodule

// File: tb/tb_de2_115_camera_led_out.sv
// tb_de2_115_camera_led_out: directed checks of the LED output port register map and blink timer.
module tb_de2_115_camera_led_out;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [17:0] out_port;
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   de2_115_camera_led_out dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] exp);
      address = a;
      tick();
      chk(tag, readdata, exp);
   endtask

   initial begin
      #2;
      chk("rst_out", 32'(out_port), 32'h0);
      chk("rst_rd", readdata, 32'h0);
      #21 reset_n = 1'b1;
      rd(3'd0, "t1_rd0", 32'h0);
      chk("t1_out", 32'(out_port), 32'h0);

      wr(3'd0, 32'h3FFFF);
      wr(3'd5, 32'h0000F);
      wr(3'd4, 32'h00001);
      chk("t2_out_lag", 32'(out_port), 32'h3FFF0);
      rd(3'd0, "t2_rd0", 32'h3FFF1);
      chk("t2_out", 32'(out_port), 32'h3FFF1);

      wr(3'd0, 32'h5);
      wr(3'd1, 32'h3);
      wr(3'd2, 32'h3);
      address = 3'd0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("t3_blink%0d", k), 32'(out_port), (((k - 1) / 4) % 2) ? 32'h6 : 32'h5);
         chk($sformatf("t3_rd%0d", k), readdata, 32'h5);
      end
      rd(3'd1, "t3_rd_en", 32'h3);
      rd(3'd2, "t3_rd_per", 32'h3);

      for (int k = 0; k < 2; k++) tick();
      wr(3'd2, 32'h0);
      tick();
      chk("t4_stop", 32'(out_port), 32'h5);
      for (int k = 0; k < 110; k++) begin
         tick();
         chk("t4_hold", 32'(out_port), 32'h5);
      end
      rd(3'd2, "t4_rd_per", 32'h0);

      wr(3'd0, 32'hFFFFFFFF);
      rd(3'd0, "t5_rd_trunc", 32'h3FFFF);
      wr(3'd6, 32'h00123);
      rd(3'd6, "t5_rd6", 32'h0);
      rd(3'd4, "t5_rd4", 32'h0);
      rd(3'd0, "t5_data_kept", 32'h3FFFF);
      address = 3'd0;
      wr(3'd0, 32'h00AAA);
      chk("t5_rd_prewrite", readdata, 32'h3FFFF);
      rd(3'd0, "t5_rd_post", 32'h00AAA);

      wr(3'd1, 32'h3FFFF);
      wr(3'd2, 32'h1);
      for (int k = 0; k < 5; k++) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("t6_out_async", 32'(out_port), 32'h0);
      chk("t6_rd_async", readdata, 32'h0);
      #10 reset_n = 1'b1;
      rd(3'd0, "t6_data", 32'h0);
      rd(3'd1, "t6_en", 32'h0);
      rd(3'd2, "t6_per", 32'h0);
      for (int k = 0; k < 4; k++) tick();
      chk("t6_out_idle", 32'(out_port), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
